dense_seq_ctrl: RTL and testbench

//   Sequencer for the fully-connected (dense) layer of the digit classifier.

---
 rtl/dense_seq_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dense_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: read sequencer for the dense (fully-connected) layer.
// Scans the pooling-2 memory (NUM_CH x PIX) once per output neuron, walks the
// weight memory linearly across all neurons, and delays the issue strobe by
// the RAM read latency to produce mac_en for the MAC datapath.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; done holds its last value
// CLEAR   | one cycle, mac_clear pulse, pixel/channel pointers rewound
// ISSUE   | one read per cycle while hold=0
// DRAIN   | wait for the last read to come out of the delay line
// EMIT    | one cycle, neuron_done pulse for neuron_idx
// FINISH  | one cycle, done rises, busy drops

module dense_seq_ctrl #(
    parameter int NUM_CH  = 12,
    parameter int PIX     = 16,
    parameter int NUM_OUT = 10,
    parameter int RD_LAT  = 2,
    parameter int WADDR_W = 11
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    hold,
    output logic [$clog2(PIX)-1:0]  p2_addr,
    output logic [3:0]              p2_ch,
    output logic [WADDR_W-1:0]      w_addr,
    output logic                    mac_clear,
    output logic                    mac_en,
    output logic [3:0]              neuron_idx,
    output logic                    neuron_done,
    output logic                    busy,
    output logic                    done
);

    localparam int AW = $clog2(PIX);
    // Every delay-line bit except the output stage; zero there means the
    // last outstanding read is being presented on mac_en this cycle.
    localparam logic [RD_LAT-1:0] DLY_MSB = RD_LAT'(1) << (RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        p2_addr_q, p2_addr_d;
    logic [3:0]           p2_ch_q, p2_ch_d;
    logic [WADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [3:0]           idx_q, idx_d;
    logic [RD_LAT-1:0]    dly_q, dly_d;
    logic                 mac_clear_q, mac_clear_d;
    logic                 neuron_done_q, neuron_done_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 issue;
    logic                 last_issue;
    logic                 last_neuron;
    logic                 accept;

    assign accept      = (state_q == S_IDLE) && start;
    assign issue       = (state_q == S_ISSUE) && !hold;
    assign last_issue  = issue && (p2_ch_q == 4'(NUM_CH - 1)) && (p2_addr_q == AW'(PIX - 1));
    assign last_neuron = (idx_q == 4'(NUM_OUT - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_ISSUE;
            S_ISSUE:  if (last_issue) state_d = S_DRAIN;
            S_DRAIN:  if ((dly_q & ~DLY_MSB) == '0) state_d = S_EMIT;
            S_EMIT:   state_d = last_neuron ? S_FINISH : S_CLEAR;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs decoded from the state being entered
    always_comb begin
        mac_clear_d   = (state_d == S_CLEAR);
        neuron_done_d = (state_d == S_EMIT);
        busy_d        = (state_d == S_CLEAR) || (state_d == S_ISSUE) ||
                        (state_d == S_DRAIN) || (state_d == S_EMIT);
        done_d        = done_q;
        if (state_d == S_FINISH) begin
            done_d = 1'b1;
        end else if (accept) begin
            done_d = 1'b0;
        end
    end

    // Address counters, neuron index and read-latency delay line
    always_comb begin
        p2_addr_d = p2_addr_q;
        p2_ch_d   = p2_ch_q;
        w_addr_d  = w_addr_q;
        idx_d     = idx_q;
        // The delay line keeps shifting during hold so stall gaps reach mac_en.
        dly_d     = (dly_q << 1) | RD_LAT'(issue);

        if (accept) begin
            w_addr_d = '0;
            idx_d    = '0;
        end

        if (state_q == S_CLEAR) begin
            p2_addr_d = '0;
            p2_ch_d   = '0;
        end

        if (issue) begin
            if (p2_addr_q == AW'(PIX - 1)) begin
                p2_addr_d = '0;
                p2_ch_d   = (p2_ch_q == 4'(NUM_CH - 1)) ? 4'd0 : p2_ch_q + 4'd1;
            end else begin
                p2_addr_d = p2_addr_q + AW'(1);
            end
            // w_addr runs across neurons and parks on the final weight.
            if (!(last_issue && last_neuron)) begin
                w_addr_d = w_addr_q + WADDR_W'(1);
            end
        end

        if ((state_q == S_EMIT) && !last_neuron) begin
            idx_d = idx_q + 4'd1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p2_addr_q     <= '0;
            p2_ch_q       <= '0;
            w_addr_q      <= '0;
            idx_q         <= '0;
            dly_q         <= '0;
            mac_clear_q   <= 1'b0;
            neuron_done_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            p2_addr_q     <= p2_addr_d;
            p2_ch_q       <= p2_ch_d;
            w_addr_q      <= w_addr_d;
            idx_q         <= idx_d;
            dly_q         <= dly_d;
            mac_clear_q   <= mac_clear_d;
            neuron_done_q <= neuron_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign p2_addr     = p2_addr_q;
    assign p2_ch       = p2_ch_q;
    assign w_addr      = w_addr_q;
    assign neuron_idx  = idx_q;
    assign mac_clear   = mac_clear_q;
    assign mac_en      = dly_q[RD_LAT-1];
    assign neuron_done = neuron_done_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Testbench for dense_seq_ctrl: table vectors, directed multi-cycle sequences
// and randomized hold/start traffic, all checked every cycle against a
// timeline model that counts reads per neuron and tracks issue times.

module tb_dense_seq_ctrl;

    localparam int NUM_CH  = 12;
    localparam int PIX     = 16;
    localparam int NUM_OUT = 10;
    localparam int RD_LAT  = 2;
    localparam int WADDR_W = 11;
    localparam int PER_N   = NUM_CH * PIX;
    localparam int LAST_W  = NUM_OUT * PER_N - 1;
    localparam int HSZ     = 16384;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic                hold;
    logic [3:0]          p2_addr;
    logic [3:0]          p2_ch;
    logic [WADDR_W-1:0]  w_addr;
    logic                mac_clear;
    logic                mac_en;
    logic [3:0]          neuron_idx;
    logic                neuron_done;
    logic                busy;
    logic                done;

    dense_seq_ctrl #(
        .NUM_CH(NUM_CH), .PIX(PIX), .NUM_OUT(NUM_OUT), .RD_LAT(RD_LAT), .WADDR_W(WADDR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold),
        .p2_addr(p2_addr), .p2_ch(p2_ch), .w_addr(w_addr),
        .mac_clear(mac_clear), .mac_en(mac_en), .neuron_idx(neuron_idx),
        .neuron_done(neuron_done), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model state
    int mc = 0;
    bit m_hist [HSZ];
    bit m_run, m_done;
    int m_n, m_k, m_tclear, m_tlast, m_tfin;

    function automatic logic [27:0] pack_out();
        return {mac_clear, mac_en, neuron_done, busy, done, neuron_idx, p2_ch, p2_addr, w_addr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic m_reset();
        m_run = 0; m_done = 0; m_n = 0; m_k = 0;
        m_tclear = -10; m_tlast = -100; m_tfin = -1;
        for (int i = 0; i < HSZ; i++) m_hist[i] = 1'b0;
    endtask

    task automatic model_check();
        logic [27:0] act_v, exp_v;
        bit clr, iss, nd, fin, en, acc;
        int wexp;
        act_v = pack_out();
        if (reset) begin
            m_reset();
            exp_v = '0;
        end else begin
            clr  = m_run && (mc == m_tclear);
            iss  = m_run && (mc > m_tclear) && (m_k < PER_N) && !hold;
            nd   = m_run && (m_k == PER_N) && (mc == m_tlast + RD_LAT + 1);
            fin  = m_run && (mc == m_tfin);
            en   = (mc >= RD_LAT) && m_hist[mc - RD_LAT];
            acc  = start && !m_run;
            wexp = m_n * PER_N + m_k;
            if (wexp > LAST_W) wexp = LAST_W;
            exp_v = {clr, en, nd, m_run && !fin, m_done || fin, 4'(m_n),
                     4'((m_k / PIX) % NUM_CH), 4'(m_k % PIX), 11'(wexp)};
            if (mc < HSZ) m_hist[mc] = iss;
            if (iss) begin
                m_k++;
                if (m_k == PER_N) m_tlast = mc;
            end
            if (nd) begin
                if (m_n < NUM_OUT - 1) begin
                    m_n++; m_k = 0; m_tclear = mc + 1;
                end else begin
                    m_tfin = mc + 1;
                end
            end
            if (fin) begin
                m_run = 0; m_done = 1;
            end
            if (acc) begin
                m_run = 1; m_done = 0; m_n = 0; m_k = 0;
                m_tclear = mc + 1; m_tfin = -1;
            end
        end
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL model cyc%0d: got %h want %h", mc, act_v, exp_v);
        end
        mc++;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic run_until_done(input int budget, input bit rnd, output int ndc);
        int n;
        n = 0; ndc = 0;
        do begin
            next_cycle();
            if (rnd) begin
                hold  = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 15) == 0);
            end else begin
                hold = 1'b0; start = 1'b0;
            end
            sample();
            n++;
            if (neuron_done) ndc++;
        end while (!done && n < budget);
        check("done_reached", done, 1);
        start = 1'b0; hold = 1'b0;
    endtask

    typedef struct {
        bit s; bit h;
        bit clr; bit en; bit bsy;
        int ch; int addr; int w;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int rel, done_rel, first_nd, nd_cnt, clr_cnt, en_cnt, nd_rel, stall_left, ndc;
        bit stalled;

        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 0, 1, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 1, 0, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 1, 0, 1, 1};
        tbl[4] = '{0, 0, 0, 1, 1, 0, 1, 1};
        tbl[5] = '{1, 0, 0, 0, 1, 0, 2, 2};
        tbl[6] = '{0, 0, 0, 1, 1, 0, 3, 3};
        tbl[7] = '{0, 0, 0, 1, 1, 0, 4, 4};

        reset = 1'b1; start = 1'b0; hold = 1'b0;
        sample();
        check("reset_init", 32'(pack_out()), 0);
        next_cycle(); reset = 1'b0;
        sample();

        // table: first cycles of a run, one-cycle stall, start ignored in ISSUE
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            start = tbl[i].s; hold = tbl[i].h;
            sample();
            check($sformatf("tbl%0d", i),
                  {mac_clear, mac_en, busy, 1'b0, p2_ch, p2_addr, 9'd0, w_addr},
                  {tbl[i].clr, tbl[i].en, tbl[i].bsy, 1'b0, 4'(tbl[i].ch), 4'(tbl[i].addr), 9'd0, 11'(tbl[i].w)});
        end
        start = 1'b0; hold = 1'b0;
        run_until_done(2500, 0, ndc);

        // restart while done=1; no-stall full-run timing
        next_cycle(); start = 1'b1; hold = 1'b0;
        sample();
        check("done_before_restart", done, 1);
        rel = 0; done_rel = -1; first_nd = -1; nd_cnt = 0; clr_cnt = 0;
        while (done_rel < 0 && rel < 2500) begin
            next_cycle(); start = 1'b0;
            sample(); rel++;
            if (rel == 1) check("done_drop", done, 0);
            if (neuron_done) begin
                nd_cnt++;
                if (first_nd < 0) first_nd = rel;
            end
            if (mac_clear) clr_cnt++;
            if (done) done_rel = rel;
        end
        check("done_rise_cycle", done_rel, 1961);
        check("first_neuron_done", first_nd, 196);
        check("neuron_done_count", nd_cnt, NUM_OUT);
        check("mac_clear_count", clr_cnt, NUM_OUT);
        check("final_w_addr", w_addr, LAST_W);
        check("busy_after_done", busy, 0);
        check("final_idx", neuron_idx, NUM_OUT - 1);

        // stall: five held cycles at ch 3 addr 7 in neuron 0
        next_cycle(); start = 1'b1; hold = 1'b0;
        sample();
        rel = 0; en_cnt = 0; nd_rel = -1; stall_left = 0; stalled = 0;
        while (nd_rel < 0 && rel < 400) begin
            next_cycle(); start = 1'b0;
            hold = (stall_left > 0);
            sample(); rel++;
            if (hold) begin
                check("stall_ch", p2_ch, 3);
                check("stall_addr", p2_addr, 7);
                check("stall_w", w_addr, 55);
                stall_left--;
            end else if (!stalled && busy && p2_ch == 4'd3 && p2_addr == 4'd6) begin
                stall_left = 5; stalled = 1;
            end
            if (mac_en) en_cnt++;
            if (neuron_done) nd_rel = rel;
        end
        hold = 1'b0;
        check("stall_seen", stalled, 1);
        check("stall_mac_en_count", en_cnt, PER_N);
        check("stall_neuron_done", nd_rel, 201);

        // asynchronous reset in the middle of a cycle
        next_cycle();
        #2 reset = 1'b1;
        #1;
        check("reset_async_outputs", 32'(pack_out()), 0);
        sample();
        next_cycle(); reset = 1'b0;
        sample();

        // reset at cycle 100 of a run, then restart from scratch
        next_cycle(); start = 1'b1;
        sample();
        for (int i = 0; i < 100; i++) begin
            next_cycle(); start = 1'b0;
            sample();
        end
        next_cycle(); reset = 1'b1;
        sample();
        check("rst100_w", w_addr, 0);
        check("rst100_mac_en", mac_en, 0);
        next_cycle(); reset = 1'b0;
        sample();
        next_cycle(); start = 1'b1;
        sample();
        next_cycle(); start = 1'b0;
        sample();
        check("restart_clear", mac_clear, 1);
        check("restart_idx", neuron_idx, 0);
        next_cycle();
        sample();
        check("restart_w", w_addr, 0);

        // randomized hold/start traffic for a full run
        run_until_done(6000, 1, ndc);
        check("rand_neuron_done_count", ndc, NUM_OUT);
        check("rand_final_w", w_addr, LAST_W);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
